// File: rtl/output_demux_pkg.sv
// Shared definitions for the output_demux packet steering block.
// Holds the state encoding, tuser field positions and FIFO sizing helper.
package output_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FWD_PKT  = 2'd1,
        ST_DROP_PKT = 2'd2
    } demux_state_e;

    localparam int TUSER_DST_POS = 24;
    localparam int TUSER_SRC_POS = 16;
    localparam int TUSER_LEN_POS = 0;

    localparam int MAX_PKT_SIZE = 2000;

    // Ceiling log2, so a FIFO sized with it always holds `value` entries.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// First-word-fallthrough FIFO: head entry is visible on dout_o while not empty.
// nearly_full_o asserts with one free slot left so a writer can stop in time.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             nearly_full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int PW    = MAX_DEPTH_BITS;
    localparam int CW    = MAX_DEPTH_BITS + 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_NF   = CW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full          = (count_q == CNT_FULL);
    assign empty_o       = (count_q == '0);
    assign nearly_full_o = (count_q >= CNT_NF);
    assign do_wr         = wr_en_i & ~full;
    assign do_rd         = rd_en_i & ~empty_o;
    assign dout_o        = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + CW'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/output_demux.sv
// 1-to-N AXI4-Stream packet demultiplexer steered by the SOP tuser dst mask.
// Each output has its own FIFO; empty-mask packets are consumed and dropped.
module output_demux
    import output_demux_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES           = 2,
    parameter int DST_PORT_POS         = TUSER_DST_POS
) (
    input  logic                                axi_aclk,
    input  logic                                axi_aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic                                s_axis_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata_0,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb_0,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser_0,
    output logic                                m_axis_tvalid_0,
    input  logic                                m_axis_tready_0,
    output logic                                m_axis_tlast_0,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata_1,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb_1,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser_1,
    output logic                                m_axis_tvalid_1,
    input  logic                                m_axis_tready_1,
    output logic                                m_axis_tlast_1,

    output logic                                pkt_fwd,
    output logic                                pkt_drop
);

    localparam int STRB_W     = C_M_AXIS_DATA_WIDTH / 8;
    localparam int ENTRY_W    = 1 + C_M_AXIS_TUSER_WIDTH + STRB_W
                              + C_M_AXIS_DATA_WIDTH;
    localparam int DEPTH_BITS = log2(MAX_PKT_SIZE / STRB_W);

    typedef logic [ENTRY_W-1:0] entry_t;

    demux_state_e          state_q;
    demux_state_e          state_d;
    logic [NUM_QUEUES-1:0] dst_mask_q;
    logic [NUM_QUEUES-1:0] dst_mask_d;
    logic                  pkt_fwd_q;
    logic                  pkt_fwd_d;
    logic                  pkt_drop_q;
    logic                  pkt_drop_d;

    logic [NUM_QUEUES-1:0] sop_mask;
    logic [NUM_QUEUES-1:0] cur_mask;
    logic [NUM_QUEUES-1:0] nearly_full;
    logic [NUM_QUEUES-1:0] empty;
    logic [NUM_QUEUES-1:0] wr_en;
    logic [NUM_QUEUES-1:0] rd_en;
    logic [NUM_QUEUES-1:0] m_tready;
    logic                  is_idle;
    logic                  accept;
    logic                  fifo_reset;

    entry_t                din;
    entry_t                dout [NUM_QUEUES];

    assign sop_mask = s_axis_tuser[DST_PORT_POS +: NUM_QUEUES];
    assign is_idle  = (state_q == ST_IDLE);
    assign cur_mask = is_idle ? sop_mask : dst_mask_q;

    // Multicast beats go to all selected ports at once or wait for all of them.
    assign s_axis_tready = ~|(cur_mask & nearly_full);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign wr_en         = {NUM_QUEUES{accept}} & cur_mask;

    assign din = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};

    always_comb begin
        state_d    = state_q;
        dst_mask_d = dst_mask_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && !s_axis_tlast) begin
                    state_d    = (|sop_mask) ? ST_FWD_PKT : ST_DROP_PKT;
                    dst_mask_d = sop_mask;
                end
            end
            ST_FWD_PKT, ST_DROP_PKT: begin
                if (accept && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pkt_fwd_d  = accept & is_idle & (|sop_mask);
    assign pkt_drop_d = accept & is_idle & ~(|sop_mask);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q    <= ST_IDLE;
            dst_mask_q <= '0;
            pkt_fwd_q  <= 1'b0;
            pkt_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dst_mask_q <= dst_mask_d;
            pkt_fwd_q  <= pkt_fwd_d;
            pkt_drop_q <= pkt_drop_d;
        end
    end

    assign pkt_fwd  = pkt_fwd_q;
    assign pkt_drop = pkt_drop_q;

    assign fifo_reset = ~axi_aresetn;
    assign m_tready   = {m_axis_tready_1, m_axis_tready_0};
    assign rd_en      = ~empty & m_tready;

    for (genvar k = 0; k < NUM_QUEUES; k++) begin : g_port
        fallthrough_small_fifo #(
            .WIDTH          (ENTRY_W),
            .MAX_DEPTH_BITS (DEPTH_BITS)
        ) u_fifo (
            .clk_i         (axi_aclk),
            .reset_i       (fifo_reset),
            .din_i         (din),
            .wr_en_i       (wr_en[k]),
            .rd_en_i       (rd_en[k]),
            .dout_o        (dout[k]),
            .nearly_full_o (nearly_full[k]),
            .empty_o       (empty[k])
        );
    end

    assign m_axis_tvalid_0 = ~empty[0];
    assign m_axis_tvalid_1 = ~empty[1];

    assign {m_axis_tlast_0, m_axis_tuser_0,
            m_axis_tstrb_0, m_axis_tdata_0} = dout[0];
    assign {m_axis_tlast_1, m_axis_tuser_1,
            m_axis_tstrb_1, m_axis_tdata_1} = dout[1];

endmodule

// File: tb/tb_output_demux.sv
// Directed bench for output_demux with a queue-based per-port reference model.
// Literal expectations pin latency, beat counts, pulses and reset behaviour.
`timescale 1ns/1ps
module tb_output_demux;

    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int UW = 128;
    localparam int EW = 1 + UW + SW + DW;
    // 64-entry port FIFO that stops accepting with one slot still free
    localparam int NF_LEVEL = 63;

    typedef logic [EW-1:0] entry_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [SW-1:0] s_tstrb = '0;
    logic [UW-1:0] s_tuser = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] m_tdata_0, m_tdata_1;
    logic [SW-1:0] m_tstrb_0, m_tstrb_1;
    logic [UW-1:0] m_tuser_0, m_tuser_1;
    logic          m_tvalid_0, m_tvalid_1;
    logic          m_tready_0 = 1'b1;
    logic          m_tready_1 = 1'b1;
    logic          m_tlast_0, m_tlast_1;
    logic          pkt_fwd, pkt_drop;

    always #5 clk = ~clk;

    output_demux dut (
        .axi_aclk        (clk),
        .axi_aresetn     (rst_n),
        .s_axis_tdata    (s_tdata),
        .s_axis_tstrb    (s_tstrb),
        .s_axis_tuser    (s_tuser),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tready   (s_tready),
        .s_axis_tlast    (s_tlast),
        .m_axis_tdata_0  (m_tdata_0),
        .m_axis_tstrb_0  (m_tstrb_0),
        .m_axis_tuser_0  (m_tuser_0),
        .m_axis_tvalid_0 (m_tvalid_0),
        .m_axis_tready_0 (m_tready_0),
        .m_axis_tlast_0  (m_tlast_0),
        .m_axis_tdata_1  (m_tdata_1),
        .m_axis_tstrb_1  (m_tstrb_1),
        .m_axis_tuser_1  (m_tuser_1),
        .m_axis_tvalid_1 (m_tvalid_1),
        .m_axis_tready_1 (m_tready_1),
        .m_axis_tlast_1  (m_tlast_1),
        .pkt_fwd         (pkt_fwd),
        .pkt_drop        (pkt_drop)
    );

    entry_t     q0[$];
    entry_t     q1[$];
    bit         in_pkt = 0;
    logic [1:0] pmask = '0;
    bit         efwd = 0;
    bit         edrop = 0;

    int n_checks = 0;
    int n_fail = 0;
    int rcv0 = 0, rcv1 = 0, last0 = 0, last1 = 0;
    int fwd_cnt = 0, drop_cnt = 0;
    bit p5_done = 0;

    task automatic check(input string name, input entry_t act, input entry_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] model_mask();
        return in_pkt ? pmask : s_tuser[25:24];
    endfunction

    function automatic bit model_ready();
        logic [1:0] m;
        m = model_mask();
        return !((m[0] && q0.size() >= NF_LEVEL) ||
                 (m[1] && q1.size() >= NF_LEVEL));
    endfunction

    // Reference model: packet steering as per-port queues
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                in_pkt = 0;
                pmask  = '0;
                efwd   = 0;
                edrop  = 0;
            end else begin
                logic [1:0] m;
                bit         acc;
                entry_t     e;
                m     = model_mask();
                acc   = s_tvalid && model_ready();
                e     = {s_tlast, s_tuser, s_tstrb, s_tdata};
                efwd  = 0;
                edrop = 0;
                if (m_tready_0 && q0.size() > 0) void'(q0.pop_front());
                if (m_tready_1 && q1.size() > 0) void'(q1.pop_front());
                if (acc) begin
                    if (m[0]) q0.push_back(e);
                    if (m[1]) q1.push_back(e);
                    if (!in_pkt) begin
                        efwd   = (m != 2'b00);
                        edrop  = (m == 2'b00);
                        pmask  = m;
                        in_pkt = !s_tlast;
                    end else if (s_tlast) begin
                        in_pkt = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_tvalid0", entry_t'(m_tvalid_0), '0);
                check("rst_tvalid1", entry_t'(m_tvalid_1), '0);
                check("rst_pkt_fwd", entry_t'(pkt_fwd), '0);
                check("rst_pkt_drop", entry_t'(pkt_drop), '0);
            end else begin
                check("s_tready", entry_t'(s_tready), entry_t'(model_ready()));
                check("tvalid0", entry_t'(m_tvalid_0), entry_t'(q0.size() != 0));
                check("tvalid1", entry_t'(m_tvalid_1), entry_t'(q1.size() != 0));
                if (q0.size() != 0)
                    check("beat0", {m_tlast_0, m_tuser_0, m_tstrb_0, m_tdata_0}, q0[0]);
                if (q1.size() != 0)
                    check("beat1", {m_tlast_1, m_tuser_1, m_tstrb_1, m_tdata_1}, q1[0]);
                check("pkt_fwd", entry_t'(pkt_fwd), entry_t'(efwd));
                check("pkt_drop", entry_t'(pkt_drop), entry_t'(edrop));
                if (pkt_fwd) fwd_cnt++;
                if (pkt_drop) drop_cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && m_tvalid_0 && m_tready_0) begin
                rcv0++;
                if (m_tlast_0) last0++;
            end
            if (rst_n && m_tvalid_1 && m_tready_1) begin
                rcv1++;
                if (m_tlast_1) last1++;
            end
        end
    end

    task automatic send_beat(input int id, input int b, input int n,
                             input logic [1:0] mask, input logic [SW-1:0] lstrb,
                             input int limit);
        logic [UW-1:0] u;
        bit            ok;
        logic [15:0]   id16;
        logic [15:0]   b16;
        id16 = 16'(id);
        b16  = 16'(b);
        u    = UW'(id * 256 + b);
        u[25:24] = (b == 0) ? mask : ~mask;
        s_tdata  = DW'({id16, b16});
        s_tuser  = u;
        s_tstrb  = (b == n - 1) ? lstrb : '1;
        s_tlast  = (b == n - 1);
        s_tvalid = 1'b1;
        ok = 0;
        for (int c = 0; c <= limit; c++) begin
            @(negedge clk);
            if (s_tready) begin
                ok = 1;
                break;
            end
        end
        check("beat_accepted", entry_t'(ok), entry_t'(1));
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int id, input int n, input logic [1:0] mask,
                            input logic [SW-1:0] lstrb, input int limit);
        for (int b = 0; b < n; b++) begin
            send_beat(id, b, n, mask, lstrb, limit);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_tvalid0", entry_t'(m_tvalid_0), '0);
        check("reset_tvalid1", entry_t'(m_tvalid_1), '0);
        check("reset_pkt_fwd", entry_t'(pkt_fwd), '0);
        check("reset_pkt_drop", entry_t'(pkt_drop), '0);
        check("reset_tready", entry_t'(s_tready), entry_t'(1));
        @(posedge clk);
        #1;

        // unicast to port 0, first beat visible the cycle after acceptance
        send_beat(1, 0, 4, 2'b01, '1, 10);
        check("uc_latency_valid", entry_t'(m_tvalid_0), entry_t'(1));
        check("uc_latency_data", entry_t'(m_tdata_0), entry_t'(32'h0001_0000));
        for (int b = 1; b < 4; b++) send_beat(1, b, 4, 2'b01, '1, 10);
        idle_cycles(6);
        check("uc_rcv0", entry_t'(rcv0), entry_t'(4));
        check("uc_rcv1", entry_t'(rcv1), entry_t'(0));
        check("uc_fwd", entry_t'(fwd_cnt), entry_t'(1));

        // multicast
        send_pkt(2, 3, 2'b11, '1, 10);
        idle_cycles(6);
        check("mc_rcv0", entry_t'(rcv0), entry_t'(7));
        check("mc_rcv1", entry_t'(rcv1), entry_t'(3));
        check("mc_last0", entry_t'(last0), entry_t'(2));
        check("mc_last1", entry_t'(last1), entry_t'(1));
        check("mc_fwd", entry_t'(fwd_cnt), entry_t'(2));

        // drop, then single-beat packet to port 1
        send_pkt(3, 5, 2'b00, '1, 0);
        send_pkt(4, 1, 2'b10, '1, 0);
        idle_cycles(6);
        check("drop_cnt", entry_t'(drop_cnt), entry_t'(1));
        check("drop_rcv0", entry_t'(rcv0), entry_t'(7));
        check("drop_rcv1", entry_t'(rcv1), entry_t'(4));
        check("drop_fwd", entry_t'(fwd_cnt), entry_t'(3));

        // backpressure with 2000-byte packets (63 beats, 16 bytes in the last)
        m_tready_0 = 1'b0;
        fork
            begin
                send_pkt(5, 63, 2'b01, 32'h0000_FFFF, 10);
                p5_done = 1;
                send_pkt(6, 63, 2'b01, 32'h0000_FFFF, 400);
            end
            begin
                for (int c = 0; c < 2000 && !p5_done; c++) @(negedge clk);
                repeat (20) @(negedge clk);
                check("bp_tready_low", entry_t'(s_tready), '0);
                check("bp_no_drain", entry_t'(rcv0), entry_t'(7));
                @(posedge clk);
                #1 m_tready_0 = 1'b1;
            end
        join
        idle_cycles(80);
        check("bp_rcv0", entry_t'(rcv0), entry_t'(133));
        check("bp_last0", entry_t'(last0), entry_t'(4));

        // port isolation: port 0 full, port 1 traffic still flows
        m_tready_0 = 1'b0;
        send_pkt(7, 63, 2'b01, 32'h0000_FFFF, 10);
        idle_cycles(2);
        send_pkt(8, 2, 2'b10, '1, 1);
        idle_cycles(4);
        check("iso_rcv1", entry_t'(rcv1), entry_t'(6));
        check("iso_rcv0", entry_t'(rcv0), entry_t'(133));
        m_tready_0 = 1'b1;
        idle_cycles(80);
        check("iso_drain0", entry_t'(rcv0), entry_t'(196));

        // reset in the middle of a 6-beat packet
        m_tready_0 = 1'b0;
        send_beat(9, 0, 6, 2'b01, '1, 10);
        send_beat(9, 1, 6, 2'b01, '1, 10);
        check("pre_rst_valid", entry_t'(m_tvalid_0), entry_t'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid0", entry_t'(m_tvalid_0), '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_tready_0 = 1'b1;
        send_beat(10, 0, 1, 2'b01, '1, 10);
        idle_cycles(4);
        check("post_rst_rcv0", entry_t'(rcv0), entry_t'(197));
        check("post_rst_fwd", entry_t'(fwd_cnt), entry_t'(9));
        check("post_rst_drop", entry_t'(drop_cnt), entry_t'(1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
